scan_decoder: RTL

Parametrised, registered N-to-2^N one-hot decoder with two operating modes. In direct mode it latches a select value and drives the matching output line. In scan mode it auto-cycles through all output lines, holding each for a programmable dwell time. It succeeds the combinational 2-to-4 decoder and drives multiplexed loads such as digit enables of a scanned 7-segment display or row strobes of a key matrix.

---
 rtl/scan_decoder.sv | 93 +++++++++
 1 files changed

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder: direct mode latches a select value,
// scan mode sweeps every line and holds each one for DWELL cycles.
module scan_decoder #(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [N-1:0]       A,
  output logic [2**N-1:0]    D,
  output logic [N-1:0]       sel,
  output logic               wrap,
  output logic [1:0]         state_dbg
);

  localparam int LINES = 2**N;
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [N-1:0]      sel_nx;
  logic              wrap_nx;
  logic              advance;
  logic [LINES-1:0]  d_nx;

  // D is decoded from the next state and next sel so all registered outputs agree.
  always_comb begin
    state_nx = IDLE;
    advance  = 1'b0;
    cnt_nx   = '0;
    sel_nx   = sel;
    wrap_nx  = 1'b0;
    d_nx     = '0;

    if (en) begin
      state_nx = mode ? SCAN : DIRECT;
    end

    // The counter only runs while staying in SCAN; entering or leaving clears it.
    if (state == SCAN && state_nx == SCAN) begin
      if (cnt == CNT_LAST) begin
        advance = 1'b1;
      end else begin
        cnt_nx = cnt + CW'(1);
      end
    end

    if (state_nx == DIRECT && load) begin
      sel_nx = A;
    end else if (advance) begin
      sel_nx = sel + N'(1);
    end

    wrap_nx = advance && (sel == {N{1'b1}});

    if (state_nx != IDLE) begin
      d_nx = LINES'(1) << sel_nx;
    end
    if (ACTIVE_LOW) begin
      d_nx = ~d_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      wrap  <= 1'b0;
      D     <= {LINES{ACTIVE_LOW}};
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sel   <= sel_nx;
      wrap  <= wrap_nx;
      D     <= d_nx;
    end
  end

  assign state_dbg = state;

endmodule
